// File: rtl/elastic_buffer_pkg.sv
// Shared symbols, state encoding and read-command codes for the RX elastic buffer controller.
package elastic_buffer_pkg;

    localparam logic [9:0] COMMA_SYMBOL = 10'h1BC;
    localparam logic [9:0] SKIP_SYMBOL  = 10'h1A1;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        RUN   = 3'd1,
        GUARD = 3'd2
    } state_t;

    typedef logic [1:0] rd_cmd_t;

    localparam rd_cmd_t RD_HOLD = 2'd0;
    localparam rd_cmd_t RD_ADV1 = 2'd1;
    localparam rd_cmd_t RD_ADV2 = 2'd2;

endpackage

// File: rtl/elastic_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for insert/delete statistics.
module elastic_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             local_clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge local_clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/elastic_buffer_ctrl.sv
// Read-side clock-compensation controller: SKIP insert/delete, start-up centring, error recovery.
// Optional statistics counters are built when ELASTIC_CTRL_STATS_EN is defined.
module elastic_buffer_ctrl
    import elastic_buffer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int CENTER       = 8,
    parameter int LOW_THRESH   = 4,
    parameter int HIGH_THRESH  = 12,
    parameter int GUARD_CYCLES = 4
) (
    input  logic              local_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W:0]   fill_level,
    input  logic [9:0]        head_symbol,
    input  logic              clear_flags,
    output logic [1:0]        rd_cmd,
    output logic              force_skip,
    output logic              flush,
    output logic              underflow_flag,
    output logic              overflow_flag,
    output logic [2:0]        state_dbg
`ifdef ELASTIC_CTRL_STATS_EN
    ,
    output logic [15:0]       insert_count,
    output logic [15:0]       delete_count
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CENTER_L = (ADDR_W+1)'(CENTER);
    localparam logic [ADDR_W:0] LOW_L    = (ADDR_W+1)'(LOW_THRESH);
    localparam logic [ADDR_W:0] HIGH_L   = (ADDR_W+1)'(HIGH_THRESH);
    localparam logic [3:0]      GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] guard_cnt;
    logic [3:0] guard_next;
    logic       set_under;
    logic       set_over;
`ifdef ELASTIC_CTRL_STATS_EN
    logic       do_insert;
    logic       do_delete;
`endif

    // Outputs are Mealy so the pointer reacts in the same cycle the condition appears.
    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        rd_cmd     = RD_HOLD;
        force_skip = 1'b1;
        flush      = 1'b0;
        set_under  = 1'b0;
        set_over   = 1'b0;
`ifdef ELASTIC_CTRL_STATS_EN
        do_insert  = 1'b0;
        do_delete  = 1'b0;
`endif
        if (!enable) begin
            state_next = INIT;
        end else begin
            case (state)
                INIT: begin
                    if (fill_level >= CENTER_L) begin
                        rd_cmd     = RD_ADV1;
                        force_skip = 1'b0;
                        state_next = RUN;
                    end
                end
                RUN, GUARD: begin
                    rd_cmd     = RD_ADV1;
                    force_skip = 1'b0;
                    if (fill_level == '0) begin
                        rd_cmd     = RD_HOLD;
                        force_skip = 1'b1;
                        set_under  = 1'b1;
                        state_next = INIT;
                    end else if (fill_level >= DEPTH_L) begin
                        rd_cmd     = RD_HOLD;
                        flush      = 1'b1;
                        set_over   = 1'b1;
                        state_next = INIT;
                    end else if ((state == RUN) && (head_symbol == SKIP_SYMBOL)
                                 && (fill_level > HIGH_L)) begin
                        rd_cmd     = RD_ADV2;
                        state_next = GUARD;
                        guard_next = GUARD_LOAD;
`ifdef ELASTIC_CTRL_STATS_EN
                        do_delete  = 1'b1;
`endif
                    end else if ((state == RUN) && (head_symbol == SKIP_SYMBOL)
                                 && (fill_level < LOW_L)) begin
                        rd_cmd     = RD_HOLD;
                        force_skip = 1'b1;
                        state_next = GUARD;
                        guard_next = GUARD_LOAD;
`ifdef ELASTIC_CTRL_STATS_EN
                        do_insert  = 1'b1;
`endif
                    end else if (state == GUARD) begin
                        if (guard_cnt == 4'd0) begin
                            state_next = RUN;
                        end else begin
                            guard_next = guard_cnt - 4'd1;
                        end
                    end
                end
                default: state_next = INIT;
            endcase
        end
        if (state_next == INIT) begin
            guard_next = 4'd0;
        end
        // Reset must silence the pointer at once, even if the inputs would start reads.
        if (!reset) begin
            rd_cmd     = RD_HOLD;
            force_skip = 1'b1;
            flush      = 1'b0;
        end
    end

    always_ff @(posedge local_clock or negedge reset) begin
        if (!reset) begin
            state          <= INIT;
            guard_cnt      <= 4'd0;
            underflow_flag <= 1'b0;
            overflow_flag  <= 1'b0;
        end else begin
            state          <= state_next;
            guard_cnt      <= guard_next;
            underflow_flag <= set_under | (underflow_flag & ~clear_flags);
            overflow_flag  <= set_over  | (overflow_flag  & ~clear_flags);
        end
    end

    assign state_dbg = state;

`ifdef ELASTIC_CTRL_STATS_EN
    elastic_ctrl_sat_counter #(.WIDTH(16)) u_insert_cnt (
        .local_clock (local_clock),
        .reset       (reset),
        .inc         (do_insert),
        .clear       (clear_flags),
        .count       (insert_count)
    );

    elastic_ctrl_sat_counter #(.WIDTH(16)) u_delete_cnt (
        .local_clock (local_clock),
        .reset       (reset),
        .inc         (do_delete),
        .clear       (clear_flags),
        .count       (delete_count)
    );
`endif

endmodule

// File: doc/elastic_buffer_ctrl.md
Name: elastic_buffer_ctrl

Overview:
Read-side clock-compensation controller for the RX elastic buffer, in the local_clock domain. Watches buffer occupancy and the symbol at the read head, and drives the read pointer command. It deletes a SKIP (double advance) when the buffer runs full and inserts a SKIP (read hold) when it runs empty, only at SKIP symbol boundaries, keeping occupancy near centre. It also handles start-up centring, hard under/overflow recovery and sticky error flags.

Parameters:
DEPTH, 16, buffer entries (power of 2)
ADDR_W, 4, log2(DEPTH); fill_level is ADDR_W+1 bits
CENTER, 8, fill level reached before reads start after reset or recovery
LOW_THRESH, 4, fill_level strictly below this requests an insert
HIGH_THRESH, 12, fill_level strictly above this requests a delete
GUARD_CYCLES, 4, cycles after an adjustment during which no further adjustment is allowed (1..15)

Ports:
local_clock  in  1  read-side clock
reset  in  1  asynchronous, active-low reset
enable  in  1  controller enable; low forces INIT
fill_level  in  ADDR_W+1  occupancy, already synchronized into local_clock
head_symbol  in  10  symbol at current read pointer
clear_flags  in  1  one-cycle pulse, clears sticky flags
rd_cmd  out  2  0 = hold, 1 = advance 1, 2 = advance 2 (delete), 3 never driven
force_skip  out  1  buffer output mux drives SKIP_SYMBOL instead of head
flush  out  1  one-cycle pulse: buffer resets both pointers
underflow_flag  out  1  sticky
overflow_flag  out  1  sticky
state_dbg  out  3  current state encoding

Behaviour:
- Reset values: state INIT, rd_cmd 0, force_skip 1, flush 0, flags 0, guard counter 0.
- Outputs are Mealy: combinational from the registered state and the current inputs. Pointer effect takes 0 cycles of latency.
- States and transitions:
  - INIT: rd_cmd 0, force_skip 1. Go to RUN when enable=1 and fill_level >= CENTER.
  - RUN: rd_cmd 1, force_skip 0. Priority, highest first:
    - fill_level == 0: underflow_flag <= 1, rd_cmd 0, force_skip 1, go to INIT.
    - fill_level == DEPTH: overflow_flag <= 1, flush 1, rd_cmd 0, go to INIT.
    - head_symbol == SKIP_SYMBOL and fill_level > HIGH_THRESH: rd_cmd 2 for one cycle, go to GUARD.
    - head_symbol == SKIP_SYMBOL and fill_level < LOW_THRESH: rd_cmd 0, force_skip 1 for one cycle, go to GUARD.
    - Otherwise stay in RUN.
  - GUARD: behaves as RUN but without the delete and insert branches. Under/overflow branches still apply. Counter loads GUARD_CYCLES-1 on entry; return to RUN when it reaches 0.
- A delete never consumes a COMMA_SYMBOL: it fires only when head is SKIP.
- enable=0 in any state: next state INIT, no flush, flags held.
- clear_flags together with a new error in the same cycle: set wins.
- fill_level values > DEPTH are treated as overflow.
- Reset mid-adjust: returns to INIT immediately. No partial command persists.

Optional Feature:
ELASTIC_CTRL_STATS_EN: when defined, adds two 16-bit saturating counters, insert_count and delete_count, as output ports. They increment on each insert or delete cycle, hold at 16'hFFFF, reset to 0, and clear on clear_flags. When undefined, neither the ports nor the logic exist.

Decomposition:
Package elastic_buffer_pkg holds:
- COMMA_SYMBOL = 10'h1BC and SKIP_SYMBOL = 10'h1A1
- state enum {INIT, RUN, GUARD}
- rd_cmd typedef/constants RD_HOLD, RD_ADV1, RD_ADV2

One sub-module is natural: elastic_ctrl_sat_counter (parameterised width, inc, clear), used for the stats counters under ELASTIC_CTRL_STATS_EN.

Test Plan:
- Reset release with fill_level ramping 0 to 8 -> rd_cmd 0 and force_skip 1 until fill=8, then rd_cmd 1 in the same cycle; state_dbg moves INIT to RUN.
- RUN with fill=13 and head 10'h1A1 -> one cycle of rd_cmd 2, then 4 GUARD cycles with rd_cmd 1 even while head remains SKIP and fill=13.
- RUN with fill=3 and head 10'h1BC -> no insert; head becomes 10'h1A1 -> one cycle of rd_cmd 0 with force_skip 1.
- fill=0 in RUN -> underflow_flag 1, return to INIT; clear_flags pulse -> flag 0 on the next edge.
- fill=16 during GUARD -> flush pulse exactly 1 cycle, overflow_flag 1, state INIT.
- Async reset asserted mid-GUARD -> all outputs at reset values immediately, without waiting for a clock edge.
